// File: rtl/pipe_issue_stage.sv
// pipe_issue_stage
// Fetch/issue front end for the regbank/ALU/writeback/mem pipeline.
// Packed instruction words are queued in a small FIFO. The head word is
// checked against a per-register scoreboard of writes still in flight.
// A head that is legal and free of hazards is decoded onto registered
// pipeline fields. A head with an illegal opcode is dropped. Whenever
// nothing issues, a harmless bubble (func=3, r0, mem[255]) is driven.

module pipe_issue_stage #(
    parameter int DEPTH   = 4,
    parameter int HAZ_WIN = 3
) (
    input  logic                     clk1,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [23:0]              in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [3:0]               rs1,
    output logic [3:0]               rs2,
    output logic [3:0]               rd,
    output logic [3:0]               func,
    output logic [7:0]               addr,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              stall_cnt,
    output logic [7:0]               illegal_cnt
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int SBW = $clog2(HAZ_WIN) + 1;

    localparam logic [CW-1:0]  FULL_COUNT   = CW'(DEPTH);
    localparam logic [SBW-1:0] SB_LOAD      = SBW'(HAZ_WIN - 1);
    localparam logic [3:0]     BUBBLE_FUNC  = 4'd3;
    localparam logic [7:0]     BUBBLE_ADDR  = 8'hFF;
    localparam logic [3:0]     FIRST_ILLEGAL = 4'd10;

    // instruction storage and its bookkeeping
    logic [23:0]    mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    // one countdown per architectural register; entry 0 is never busy
    logic [SBW-1:0] sb [16];

    // decoded view of the FIFO head
    logic [23:0]    head;
    logic [3:0]     head_func;
    logic [3:0]     head_rd;
    logic [3:0]     head_rs1;
    logic [3:0]     head_rs2;
    logic [7:0]     head_addr;

    logic           fifo_empty;
    logic           fifo_full;
    logic           head_valid;
    logic           head_legal;
    logic           rs1_busy;
    logic           rs2_busy;
    logic           hazard;
    logic           do_push;
    logic           do_pop;
    logic           do_issue;
    logic           do_drop;
    logic           do_stall;

    assign head      = mem[rd_ptr];
    assign head_func = head[23:20];
    assign head_rd   = head[19:16];
    assign head_rs1  = head[15:12];
    assign head_rs2  = head[11:8];
    assign head_addr = head[7:0];

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);

    // in_ready comes only from state, so a pop in the same cycle never frees a full FIFO
    assign in_ready   = !fifo_full;
    assign fifo_count = count;

    // Head classification and the handshake decisions for this cycle.
    // Flush overrides everything: no push, no pop, no stall is counted.
    always_comb begin
        head_valid = !fifo_empty;
        head_legal = (head_func < FIRST_ILLEGAL);
        rs1_busy   = (head_rs1 != 4'd0) && (sb[head_rs1] != '0);
        rs2_busy   = (head_rs2 != 4'd0) && (sb[head_rs2] != '0);
        hazard     = head_valid && (rs1_busy || rs2_busy);
        do_push    = in_valid && !fifo_full && !flush;
        do_pop     = head_valid && !hazard && !flush;
        do_issue   = do_pop && head_legal;
        do_drop    = do_pop && !head_legal;
        do_stall   = hazard && !flush;
    end

    // FIFO data array; contents need no reset because count guards every read
    always_ff @(posedge clk1) begin
        if (do_push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Scoreboard countdowns; an issue loads its destination, the rest drain.
    // Flush leaves it alone because issued writes are still in the pipeline.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                sb[i] <= '0;
            end
        end else begin
            sb[0] <= '0;
            for (int i = 1; i < 16; i++) begin
                if (do_issue && (head_rd == 4'(i))) begin
                    sb[i] <= SB_LOAD;
                end else if (sb[i] != '0) begin
                    sb[i] <= sb[i] - SBW'(1);
                end
            end
        end
    end

    // Registered pipeline fields: the decoded head on issue, a bubble otherwise
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            func      <= BUBBLE_FUNC;
            rs1       <= 4'd0;
            rs2       <= 4'd0;
            rd        <= 4'd0;
            addr      <= BUBBLE_ADDR;
        end else if (do_issue) begin
            out_valid <= 1'b1;
            func      <= head_func;
            rs1       <= head_rs1;
            rs2       <= head_rs2;
            rd        <= head_rd;
            addr      <= head_addr;
        end else begin
            out_valid <= 1'b0;
            func      <= BUBBLE_FUNC;
            rs1       <= 4'd0;
            rs2       <= 4'd0;
            rd        <= 4'd0;
            addr      <= BUBBLE_ADDR;
        end
    end

    // Saturating event counters for hazard stalls and dropped opcodes
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= 16'd0;
            illegal_cnt <= 8'd0;
        end else begin
            if (do_stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (do_drop && (illegal_cnt != 8'hFF)) begin
                illegal_cnt <= illegal_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_issue_stage.sv
// tb_pipe_issue_stage
// Directed scenarios followed by a random stream, all checked every cycle
// against a queue-based reference model. Register readiness is tracked as
// the earliest edge at which a register may be read again.

module tb_pipe_issue_stage;

    localparam int DEPTH   = 4;
    localparam int HAZ_WIN = 4;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic            clk1 = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [23:0]     in_instr;
    logic            flush;
    logic            out_valid;
    logic [3:0]      rs1;
    logic [3:0]      rs2;
    logic [3:0]      rd;
    logic [3:0]      func;
    logic [7:0]      addr;
    logic [CW-1:0]   fifo_count;
    logic [15:0]     stall_cnt;
    logic [7:0]      illegal_cnt;

    int compared   = 0;
    int mismatched = 0;

    // reference model state
    logic [23:0] model_q [$];
    int          ready_at [16];
    int          edge_no = 0;
    logic        exp_valid;
    logic [3:0]  exp_func;
    logic [3:0]  exp_rs1;
    logic [3:0]  exp_rs2;
    logic [3:0]  exp_rd;
    logic [7:0]  exp_addr;
    int          exp_stall;
    int          exp_illegal;
    bit          accepted;

    pipe_issue_stage #(
        .DEPTH   (DEPTH),
        .HAZ_WIN (HAZ_WIN)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .flush       (flush),
        .out_valid   (out_valid),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .func        (func),
        .addr        (addr),
        .fifo_count  (fifo_count),
        .stall_cnt   (stall_cnt),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [23:0] mk(input int f, input int d, input int a, input int b, input int ad);
        return {4'(f), 4'(d), 4'(a), 4'(b), 8'(ad)};
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelBubble();
        exp_valid = 1'b0;
        exp_func  = 4'd3;
        exp_rs1   = 4'd0;
        exp_rs2   = 4'd0;
        exp_rd    = 4'd0;
        exp_addr  = 8'hFF;
    endtask

    task automatic modelReset();
        model_q.delete();
        for (int i = 0; i < 16; i++) ready_at[i] = 0;
        modelBubble();
        exp_stall   = 0;
        exp_illegal = 0;
    endtask

    // One clock edge of the architectural behaviour
    task automatic modelEdge(input logic v, input logic [23:0] w, input logic f);
        logic [23:0] h;
        int          hf, hd, ha, hb;
        bit          room;
        bit          blocked;
        room = (model_q.size() < DEPTH);
        modelBubble();
        if (f) begin
            model_q.delete();
        end else begin
            if (model_q.size() > 0) begin
                h  = model_q[0];
                hf = int'(h[23:20]);
                hd = int'(h[19:16]);
                ha = int'(h[15:12]);
                hb = int'(h[11:8]);
                blocked = (ha != 0 && edge_no < ready_at[ha]) ||
                          (hb != 0 && edge_no < ready_at[hb]);
                if (blocked) begin
                    if (exp_stall < 65535) exp_stall++;
                end else begin
                    void'(model_q.pop_front());
                    if (hf >= 10) begin
                        if (exp_illegal < 255) exp_illegal++;
                    end else begin
                        exp_valid = 1'b1;
                        exp_func  = h[23:20];
                        exp_rd    = h[19:16];
                        exp_rs1   = h[15:12];
                        exp_rs2   = h[11:8];
                        exp_addr  = h[7:0];
                        if (hd != 0) ready_at[hd] = edge_no + HAZ_WIN;
                    end
                end
            end
            if (v && room) model_q.push_back(w);
        end
        edge_no++;
    endtask

    task automatic checkOutput();
        cmp("out_valid",   out_valid,   exp_valid);
        cmp("func",        func,        exp_func);
        cmp("rs1",         rs1,         exp_rs1);
        cmp("rs2",         rs2,         exp_rs2);
        cmp("rd",          rd,          exp_rd);
        cmp("addr",        addr,        exp_addr);
        cmp("fifo_count",  fifo_count,  model_q.size());
        cmp("stall_cnt",   stall_cnt,   exp_stall);
        cmp("illegal_cnt", illegal_cnt, exp_illegal);
    endtask

    // Drive one cycle from a negedge, step the model at the posedge, check after it
    task automatic applyStimulus(input logic v, input logic [23:0] w, input logic f);
        logic rdy_exp;
        in_valid = v;
        in_instr = w;
        flush    = f;
        rdy_exp  = (model_q.size() < DEPTH);
        cmp("in_ready", in_ready, rdy_exp);
        accepted = v && rdy_exp && !f;
        @(posedge clk1);
        modelEdge(v, w, f);
        #1;
        checkOutput();
        @(negedge clk1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 24'd0, 1'b0);
    endtask

    // Asynchronous reset checked before any clock edge can occur
    task automatic doReset();
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        modelReset();
        cmp("rst_out_valid",   out_valid,   1'b0);
        cmp("rst_func",        func,        4'd3);
        cmp("rst_addr",        addr,        8'hFF);
        cmp("rst_rd",          rd,          4'd0);
        cmp("rst_in_ready",    in_ready,    1'b1);
        cmp("rst_fifo_count",  fifo_count,  0);
        cmp("rst_stall_cnt",   stall_cnt,   0);
        cmp("rst_illegal_cnt", illegal_cnt, 0);
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    initial begin
        int s0;
        int i0;
        int tries;
        logic [23:0] w;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = 24'd0;
        flush    = 1'b0;
        @(negedge clk1);
        $display("[TB] reset");
        doReset();

        $display("[TB] independent stream");
        applyStimulus(1'b1, mk(1, 10, 3, 5, 8'h10), 1'b0);
        applyStimulus(1'b1, mk(4, 12, 3, 8, 8'h11), 1'b0);
        cmp("t2_first_valid", out_valid, 1'b1);
        cmp("t2_first_rd", rd, 4'd10);
        applyStimulus(1'b1, mk(2, 14, 7, 6, 8'h12), 1'b0);
        cmp("t2_second_valid", out_valid, 1'b1);
        cmp("t2_second_rd", rd, 4'd12);
        idle(1);
        cmp("t2_third_valid", out_valid, 1'b1);
        cmp("t2_third_rd", rd, 4'd14);
        cmp("t2_no_stall", stall_cnt, 0);

        $display("[TB] RAW hazard");
        idle(HAZ_WIN);
        s0 = exp_stall;
        applyStimulus(1'b1, mk(1, 10, 1, 2, 8'h20), 1'b0);
        applyStimulus(1'b1, mk(2, 11, 10, 0, 8'h21), 1'b0);
        cmp("t3_producer_rd", rd, 4'd10);
        for (int k = 1; k < HAZ_WIN; k++) begin
            idle(1);
            cmp("t3_bubble", out_valid, 1'b0);
        end
        idle(1);
        cmp("t3_consumer_valid", out_valid, 1'b1);
        cmp("t3_consumer_rs1", rs1, 4'd10);
        cmp("t3_stalls", stall_cnt, s0 + HAZ_WIN - 1);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, mk(1, 7, 0, 0, 8'h30), 1'b0);
        applyStimulus(1'b1, mk(1, 8, 7, 0, 8'h31), 1'b0);
        doReset();

        $display("[TB] backpressure");
        applyStimulus(1'b1, mk(1, 5, 0, 0, 8'h40), 1'b0);
        applyStimulus(1'b1, mk(1, 6, 5, 0, 8'h41), 1'b0);
        for (int k = 1; k <= DEPTH; k++) begin
            w = mk(2, 6 + k, 0, 0, 8'h41 + k);
            tries = 0;
            do begin
                applyStimulus(1'b1, w, 1'b0);
                tries++;
            end while (!accepted && tries < 20);
            cmp("t4_accepted", accepted, 1'b1);
            if (k == DEPTH) cmp("t4_extra_word_tries", tries, 2);
        end
        idle(DEPTH + 2);

        $display("[TB] illegal opcode");
        idle(HAZ_WIN);
        i0 = exp_illegal;
        applyStimulus(1'b1, mk(1, 2, 0, 0, 8'h50), 1'b0);
        applyStimulus(1'b1, mk(11, 4, 0, 0, 8'h51), 1'b0);
        cmp("t5_first_add", rd, 4'd2);
        applyStimulus(1'b1, mk(1, 3, 0, 0, 8'h52), 1'b0);
        cmp("t5_dropped_bubble", out_valid, 1'b0);
        idle(1);
        cmp("t5_second_add", rd, 4'd3);
        cmp("t5_illegal_cnt", illegal_cnt, i0 + 1);

        $display("[TB] flush");
        idle(HAZ_WIN);
        applyStimulus(1'b1, mk(1, 9, 0, 0, 8'h60), 1'b0);
        applyStimulus(1'b1, mk(1, 12, 9, 0, 8'h61), 1'b0);
        applyStimulus(1'b1, mk(1, 13, 0, 12, 8'h62), 1'b0);
        applyStimulus(1'b1, mk(1, 14, 0, 0, 8'h63), 1'b0);
        applyStimulus(1'b1, mk(1, 15, 0, 0, 8'h64), 1'b0);
        idle(1);
        cmp("t6_producer_rd", rd, 4'd12);
        cmp("t6_queued", fifo_count, 3);
        applyStimulus(1'b1, mk(1, 1, 0, 0, 8'h65), 1'b1);
        cmp("t6_flush_empty", fifo_count, 0);
        cmp("t6_flush_bubble", out_valid, 1'b0);
        applyStimulus(1'b1, mk(2, 2, 0, 12, 8'h66), 1'b0);
        idle(1);
        cmp("t6_still_blocked", out_valid, 1'b0);
        idle(1);
        cmp("t6_consumer_valid", out_valid, 1'b1);
        cmp("t6_consumer_rs2", rs2, 4'd12);

        $display("[TB] random stream");
        for (int c = 0; c < 400; c++) begin
            if (c == 200) doReset();
            w = mk($urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 255));
            applyStimulus(($urandom_range(0, 3) != 0), w, ($urandom_range(0, 19) == 0));
        end
        idle(DEPTH * HAZ_WIN + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
